// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    HALT = 2'd2
  } arb_state_e;

  localparam int unsigned PORT_F         = 0;
  localparam int unsigned PORT_D         = 1;
  localparam int unsigned STARVE_MAX_DEF = 3;
  localparam int unsigned CTR_W          = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating counter of consecutive denied fetch cycles; clr wins over inc.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CTR_W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == CTR_W'(MAX));

  // NOTE: cnt_d gets a default first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arb2.sv
// Fetch/data arbiter for the shared memory: combinational grant and memory drive,
// registered one-cycle responses, and the end-of-program dump/halt sequence.
module mem_arb2
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [15:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  output logic        d_err,
  input  logic        dump_req,
  output logic        dump_done,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_createdump,
  input  logic [15:0] mem_data_out
);

  arb_state_e  state_q;
  logic        at_max;
  logic        can_grant;
  logic [1:0]  gnt;
  logic        f_acc, d_acc;

  logic        f_rvalid_q, f_err_q, d_rvalid_q, d_err_q;
  logic [15:0] f_rdata_q, d_rdata_q;
  logic        createdump_q, dump_done_q;

  // A dump request blocks grants in the very cycle it is seen.
  assign can_grant = !rst && (state_q == RUN) && !dump_req;

  assign gnt[PORT_F] = can_grant && f_req && (at_max || !d_req);
  assign gnt[PORT_D] = can_grant && d_req && !(at_max && f_req);

  // Odd addresses are granted but never reach the memory.
  assign f_acc = gnt[PORT_F] && !f_addr[0];
  assign d_acc = gnt[PORT_D] && !d_addr[0];

  assign mem_enable  = f_acc || d_acc;
  assign mem_wr      = d_acc && d_wr;
  assign mem_addr    = f_acc ? f_addr : (d_acc ? d_addr : 16'h0000);
  assign mem_data_in = (d_acc && d_wr) ? d_wdata : 16'h0000;

  mem_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (f_req && !gnt[PORT_F]),
    .clr    (gnt[PORT_F] || !f_req),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      createdump_q <= 1'b0;
      dump_done_q  <= 1'b0;
      f_rvalid_q   <= 1'b0;
      f_err_q      <= 1'b0;
      f_rdata_q    <= '0;
      d_rvalid_q   <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        RUN:     if (dump_req) state_q <= DUMP;
        DUMP:    state_q <= HALT;
        HALT:    state_q <= HALT;
        default: state_q <= RUN;
      endcase
      createdump_q <= (state_q == RUN) && dump_req;
      dump_done_q  <= (state_q == DUMP) || (state_q == HALT);

      f_rvalid_q <= gnt[PORT_F];
      f_err_q    <= gnt[PORT_F] && f_addr[0];
      f_rdata_q  <= f_acc ? mem_data_out : 16'h0000;
      d_rvalid_q <= gnt[PORT_D];
      d_err_q    <= gnt[PORT_D] && d_addr[0];
      d_rdata_q  <= (d_acc && !d_wr) ? mem_data_out : 16'h0000;
    end
  end

  // Outputs are masked while rst is high so a reset cycle reads all-zero immediately.
  assign f_gnt          = gnt[PORT_F];
  assign d_gnt          = gnt[PORT_D];
  assign f_rvalid       = f_rvalid_q && !rst;
  assign f_err          = f_err_q && !rst;
  assign f_rdata        = rst ? 16'h0000 : f_rdata_q;
  assign d_rvalid       = d_rvalid_q && !rst;
  assign d_err          = d_err_q && !rst;
  assign d_rdata        = rst ? 16'h0000 : d_rdata_q;
  assign mem_createdump = createdump_q && !rst;
  assign dump_done      = dump_done_q && !rst;

endmodule

// File: tb/tb_mem_arb2.sv
// Scoreboard bench for mem_arb2 with a behavioural memory behind the arbiter.
module tb_mem_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_wr, dump_req;
  logic [15:0] f_addr, d_addr, d_wdata;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, dump_done;
  logic [15:0] f_rdata, d_rdata;
  logic        mem_enable, mem_wr, mem_createdump;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;

  logic [15:0] ram     [0:255];
  logic [15:0] exp_ram [0:255];

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } resp_t;

  resp_t f_q[$];
  resp_t d_q[$];

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  mem_arb2 #(.STARVE_MAX(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .f_req          (f_req),
    .f_addr         (f_addr),
    .f_gnt          (f_gnt),
    .f_rvalid       (f_rvalid),
    .f_rdata        (f_rdata),
    .f_err          (f_err),
    .d_req          (d_req),
    .d_wr           (d_wr),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_gnt          (d_gnt),
    .d_rvalid       (d_rvalid),
    .d_rdata        (d_rdata),
    .d_err          (d_err),
    .dump_req       (dump_req),
    .dump_done      (dump_done),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_createdump (mem_createdump),
    .mem_data_out   (mem_data_out)
  );

  assign mem_data_out = ram[mem_addr[8:1]];

  always @(posedge clk)
    if (mem_enable && mem_wr) ram[mem_addr[8:1]] <= mem_data_in;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check responses due now, check grants and memory drive
  // against the expected grant, queue the responses those grants owe.
  task automatic step(input logic ef, input logic ed, input logic ecd, input logic edone);
    resp_t       r;
    logic        ee, ew;
    logic [15:0] ea;
    @(negedge clk);
    if (rst) begin
      check("f_rvalid_in_rst", {15'b0, f_rvalid}, 16'h0);
      check("d_rvalid_in_rst", {15'b0, d_rvalid}, 16'h0);
      f_q.delete();
      d_q.delete();
    end else begin
      if (f_q.size() > 0) begin
        r = f_q.pop_front();
        check("f_rvalid", {15'b0, f_rvalid}, 16'h1);
        check("f_rdata",  f_rdata, r.rdata);
        check("f_err",    {15'b0, f_err}, {15'b0, r.err});
      end else begin
        check("f_rvalid_idle", {15'b0, f_rvalid}, 16'h0);
      end
      if (d_q.size() > 0) begin
        r = d_q.pop_front();
        check("d_rvalid", {15'b0, d_rvalid}, 16'h1);
        check("d_rdata",  d_rdata, r.rdata);
        check("d_err",    {15'b0, d_err}, {15'b0, r.err});
      end else begin
        check("d_rvalid_idle", {15'b0, d_rvalid}, 16'h0);
      end
    end
    check("f_gnt",          {15'b0, f_gnt}, {15'b0, ef});
    check("d_gnt",          {15'b0, d_gnt}, {15'b0, ed});
    check("mem_createdump", {15'b0, mem_createdump}, {15'b0, ecd});
    check("dump_done",      {15'b0, dump_done}, {15'b0, edone});

    ee = (ef && !f_addr[0]) || (ed && !d_addr[0]);
    ew = ed && d_wr && !d_addr[0];
    ea = !ee ? 16'h0000 : (ef ? f_addr : d_addr);
    check("mem_enable",  {15'b0, mem_enable}, {15'b0, ee});
    check("mem_wr",      {15'b0, mem_wr}, {15'b0, ew});
    check("mem_addr",    mem_addr, ea);
    check("mem_data_in", mem_data_in, ew ? d_wdata : 16'h0000);

    if (ef) begin
      r.err   = f_addr[0];
      r.rdata = f_addr[0] ? 16'h0000 : exp_ram[f_addr[8:1]];
      f_q.push_back(r);
    end
    if (ed) begin
      r.err   = d_addr[0];
      r.rdata = (d_addr[0] || d_wr) ? 16'h0000 : exp_ram[d_addr[8:1]];
      d_q.push_back(r);
      if (ew) exp_ram[d_addr[8:1]] = d_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'(i * 16'h0101) ^ 16'h3C00;
      exp_ram[i] = 16'(i * 16'h0101) ^ 16'h3C00;
    end
    ram[8]     = 16'hA55A;
    exp_ram[8] = 16'hA55A;

    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; dump_req = 1'b0;
    f_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    @(posedge clk); #1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);

    // Single fetch read returning the preloaded word.
    f_req = 1'b1; f_addr = 16'h0010;
    step(1, 0, 0, 0);
    f_req = 1'b0;
    step(0, 0, 0, 0);

    // Data write, then read-back of the same address.
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    step(0, 1, 0, 0);
    d_wr = 1'b0;
    step(0, 1, 0, 0);
    d_req = 1'b0;
    step(0, 0, 0, 0);

    // Both ports requesting continuously: d,d,d,f repeating.
    f_req = 1'b1; f_addr = 16'h0040;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0042;
    for (int i = 0; i < 8; i++)
      step((i % 4) == 3, (i % 4) != 3, 0, 0);
    f_req = 1'b0; d_req = 1'b0;
    step(0, 0, 0, 0);

    // Odd addresses on each port, and an odd write that must not reach memory.
    d_req = 1'b1; d_addr = 16'h0021;
    step(0, 1, 0, 0);
    d_wr = 1'b1; d_addr = 16'h0023; d_wdata = 16'hBEEF;
    step(0, 1, 0, 0);
    d_req = 1'b0; d_wr = 1'b0;
    f_req = 1'b1; f_addr = 16'h0011;
    step(1, 0, 0, 0);
    f_addr = 16'h0022;
    step(1, 0, 0, 0);
    f_req = 1'b0;
    step(0, 0, 0, 0);

    // Dump with both requests pending, then reset out of HALT.
    f_req = 1'b1; f_addr = 16'h0010;
    d_req = 1'b1; d_addr = 16'h0020;
    dump_req = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0; f_req = 1'b0; d_req = 1'b0; dump_req = 1'b0;
    step(0, 0, 0, 0);
    f_req = 1'b1; f_addr = 16'h0020;
    step(1, 0, 0, 0);
    f_req = 1'b0;
    step(0, 0, 0, 0);

    // Reset right after a grant discards the pending response.
    d_req = 1'b1; d_addr = 16'h0010;
    step(0, 1, 0, 0);
    d_req = 1'b0; rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arb2.md
# mem_arb2

Two-port arbiter and sequencer for the processor's single shared 16-bit, byte-addressable data/instruction memory. It accepts read requests from the fetch stage and read/write requests from the memory stage, and grants at most one per cycle with data-port priority plus a starvation guard for fetch. It drives the memory's enable/wr/addr/data_in combinationally, registers read data into per-port responses, and runs the end-of-program dump/halt sequence. It sits between the pipeline and the memory instance, one level below the processor top.

## Interface
Parameters:
- STARVE_MAX, 3: consecutive denied fetch-request cycles after which fetch takes priority (range 1..15).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- f_req  in  1  fetch read request; held until f_gnt.
- f_addr  in  16  fetch byte address.
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  fetch read data valid; one-cycle pulse.
- f_rdata  out  16  fetch read data.
- d_req  in  1  data request; held with d_wr/d_addr/d_wdata stable until d_gnt.
- d_wr  in  1  1 = write, 0 = read.
- d_addr  in  16  data byte address.
- d_wdata  in  16  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response (read data or write ack); one-cycle pulse.
- d_rdata  out  16  data read data; 0 for write acks.
- d_err  out  1  pulse with d_rvalid: odd address, access suppressed.
- f_err  out  1  pulse with f_rvalid: odd address, access suppressed.
- dump_req  in  1  halt request from writeback; level, held.
- dump_done  out  1  high in HALT state.
- mem_enable, mem_wr  out  1  memory controls.
- mem_addr, mem_data_in  out  16  memory address/write data.
- mem_createdump  out  1  memory dump strobe.
- mem_data_out  in  16  memory combinational read data.

## Operation
- FSM states RUN, DUMP, HALT; reset state RUN.
- RUN: winner = data if d_req, unless fetch starve counter == STARVE_MAX and f_req, then fetch. Loser is not granted and must hold.
- Granted access drives mem_enable=1, mem_wr (0 for fetch), mem_addr, and mem_data_in combinationally in the grant cycle. Read data mem_data_out is captured at that edge into the port's rdata register.
- Odd address: gnt still asserted, mem_enable=0, and the response carries err=1 with rdata=0.
- Starve counter: increments (saturating at STARVE_MAX) on each cycle with f_req && !f_gnt. Clears on f_gnt or when !f_req.
- RUN to DUMP: dump_req=1. No grants are issued in the cycle dump_req is seen or afterwards; responses for already-granted accesses still issue.
- DUMP: mem_createdump=1 for exactly one cycle, no grants. Then go to HALT.
- HALT: dump_done=1, no grants, mem_enable=0. Exit only via rst.
- Idle cycles: mem_* outputs are all 0.

## Timing
- Grant is combinational from req in the same cycle. Response is exactly 1 cycle later: rvalid registered, throughput 1 access/cycle total.
- Write takes effect at the grant-cycle edge. d_rvalid ack follows on the next cycle.
- Back-to-back same-port grants produce back-to-back rvalid pulses.
- Simultaneous f_req and d_req with counter < STARVE_MAX: d wins, and the counter increments.
- Reset, including mid-access or mid-DUMP: every output goes to 0, state to RUN, counter to 0, and pending responses are discarded.
- dump_req and a request in the same cycle: no grant; DUMP on the next cycle.

## Structure
- Package mem_arb_pkg holds the state enum (RUN/DUMP/HALT), the port index constants (PORT_F=0, PORT_D=1), and the default STARVE_MAX.
- One sub-module, mem_arb_starve_ctr: a saturating counter with inc/clr inputs and an at_max output. Everything else stays in mem_arb2.

## Test plan
- Single fetch read at 0x0010, with memory returning 0xA55A → f_gnt same cycle; f_rvalid=1, f_rdata=0xA55A next cycle.
- d write 0x1234 at 0x0020, then d read at 0x0020 → mem_wr=1 in cycle 0; d_rvalid ack with rdata 0 in cycle 1; read returns 0x1234 in cycle 2.
- f_req and d_req held continuously with STARVE_MAX=3 → grant pattern d,d,d,f repeating.
- d read at 0x0021 → d_gnt=1, mem_enable=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
- dump_req asserted with both reqs pending → no grants, mem_createdump pulses one cycle later, dump_done stays high; rst returns the block to RUN with outputs 0.
- rst asserted in the cycle after a grant → no rvalid is emitted and all outputs read 0.
